// File: rtl/dma_coh_arb.sv
// Round-robin arbiter sharing one coherence master port between N DMA clients.
// The granted client's bundle is forwarded to the fabric; responses return to that client only.
module dma_coh_arb #(
    parameter int unsigned N   = 2,
    parameter int unsigned GAP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    c_lock,
    input  logic [8*N-1:0]  c_rqst,
    input  logic [8*N-1:0]  c_trsc,
    input  logic [64*N-1:0] c_addr,
    output logic [8*N-1:0]  c_resp,
    output logic [8*N-1:0]  c_mesi,
    output logic [N-1:0]    c_gnt,
    output logic            m_coh_lock,
    output logic [7:0]      m_coh_rqst,
    output logic [7:0]      m_coh_trsc,
    output logic [63:0]     m_coh_addr,
    input  logic [7:0]      m_coh_resp,
    input  logic [7:0]      m_coh_mesi
);

    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDrain, StGap} state_e;

    state_e      state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] pick;
    logic          pick_vld;
    logic [N-1:0]  c_gnt_q, c_gnt_d;
    logic          outstanding_q, outstanding_d;
    logic [3:0]    gap_q, gap_d;
    logic          gnt_lock;
    int unsigned   gidx;

    assign gidx     = 32'(gnt_q);
    assign gnt_lock = c_lock[gnt_q];
    assign c_gnt    = c_gnt_q;

    // Round-robin search from ptr upward; higher offsets are overwritten by lower ones.
    always_comb begin
        int unsigned idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_q) + N - 1 - k;
            if (idx >= N) idx = idx - N;
            if (c_lock[idx[GW-1:0]]) begin
                pick     = idx[GW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        m_coh_lock = 1'b0;
        m_coh_rqst = '0;
        m_coh_trsc = '0;
        m_coh_addr = '0;
        c_resp     = '0;
        c_mesi     = '0;
        case (state_q)
            StBusy: begin
                m_coh_lock            = gnt_lock;
                m_coh_rqst            = c_rqst[8*gidx +: 8];
                m_coh_trsc            = c_trsc[8*gidx +: 8];
                m_coh_addr            = c_addr[64*gidx +: 64];
                c_resp[8*gidx +: 8]   = m_coh_resp;
                c_mesi[8*gidx +: 8]   = m_coh_mesi;
            end
            StDrain: begin
                m_coh_trsc            = c_trsc[8*gidx +: 8];
                m_coh_addr            = c_addr[64*gidx +: 64];
                c_resp[8*gidx +: 8]   = m_coh_resp;
                c_mesi[8*gidx +: 8]   = m_coh_mesi;
            end
            default: ;
        endcase
    end

    // A response in the same cycle as a new request leaves the flag clear.
    always_comb begin
        outstanding_d = outstanding_q;
        if (m_coh_resp != 8'd0) outstanding_d = 1'b0;
        else if (m_coh_rqst != 8'd0) outstanding_d = 1'b1;
    end

    always_comb begin
        logic release_gnt;
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        c_gnt_d     = c_gnt_q;
        gap_d       = gap_q;
        release_gnt = 1'b0;
        case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    state_d       = StBusy;
                    gnt_d         = pick;
                    c_gnt_d       = '0;
                    c_gnt_d[pick] = 1'b1;
                end
            end
            StBusy: begin
                if (!gnt_lock) begin
                    if (outstanding_d) begin
                        state_d = StDrain;
                        c_gnt_d = '0;
                        ptr_d   = (gnt_q == GW'(N - 1)) ? '0 : gnt_q + 1'b1;
                    end else begin
                        release_gnt = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (m_coh_resp != 8'd0) release_gnt = 1'b1;
            end
            StGap: begin
                if (gap_q == 4'(GAP - 1)) state_d = StIdle;
                else gap_d = gap_q + 4'd1;
            end
            default: state_d = StIdle;
        endcase
        if (release_gnt) begin
            state_d = (GAP == 0) ? StIdle : StGap;
            gap_d   = '0;
            c_gnt_d = '0;
            ptr_d   = (gnt_q == GW'(N - 1)) ? '0 : gnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            gnt_q         <= '0;
            ptr_q         <= '0;
            c_gnt_q       <= '0;
            outstanding_q <= 1'b0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            ptr_q         <= ptr_d;
            c_gnt_q       <= c_gnt_d;
            outstanding_q <= outstanding_d;
            gap_q         <= gap_d;
        end
    end

endmodule

// File: tb/tb_dma_coh_arb.sv
// Directed bench for dma_coh_arb: a GAP=1 instance and a GAP=0 instance on shared inputs.
module tb_dma_coh_arb;

    logic         clk;
    logic         rst;
    logic [1:0]   c_lock;
    logic [15:0]  c_rqst;
    logic [15:0]  c_trsc;
    logic [127:0] c_addr;
    logic [7:0]   m_coh_resp;
    logic [7:0]   m_coh_mesi;

    logic [15:0]  c_resp, c_mesi;
    logic [1:0]   c_gnt;
    logic         m_coh_lock;
    logic [7:0]   m_coh_rqst, m_coh_trsc;
    logic [63:0]  m_coh_addr;

    logic [15:0]  g0_c_resp, g0_c_mesi;
    logic [1:0]   g0_c_gnt;
    logic         g0_m_coh_lock;
    logic [7:0]   g0_m_coh_rqst, g0_m_coh_trsc;
    logic [63:0]  g0_m_coh_addr;

    int nvec = 0;
    int nerr = 0;

    dma_coh_arb #(.N(2), .GAP(1)) dut (
        .clk(clk), .rst(rst), .c_lock(c_lock), .c_rqst(c_rqst), .c_trsc(c_trsc),
        .c_addr(c_addr), .c_resp(c_resp), .c_mesi(c_mesi), .c_gnt(c_gnt),
        .m_coh_lock(m_coh_lock), .m_coh_rqst(m_coh_rqst), .m_coh_trsc(m_coh_trsc),
        .m_coh_addr(m_coh_addr), .m_coh_resp(m_coh_resp), .m_coh_mesi(m_coh_mesi)
    );

    dma_coh_arb #(.N(2), .GAP(0)) dut_g0 (
        .clk(clk), .rst(rst), .c_lock(c_lock), .c_rqst(c_rqst), .c_trsc(c_trsc),
        .c_addr(c_addr), .c_resp(g0_c_resp), .c_mesi(g0_c_mesi), .c_gnt(g0_c_gnt),
        .m_coh_lock(g0_m_coh_lock), .m_coh_rqst(g0_m_coh_rqst), .m_coh_trsc(g0_m_coh_trsc),
        .m_coh_addr(g0_m_coh_addr), .m_coh_resp(m_coh_resp), .m_coh_mesi(m_coh_mesi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; c_lock = '0; c_rqst = '0; c_trsc = '0; c_addr = '0;
        m_coh_resp = '0; m_coh_mesi = '0;
        step(); step(); #2;
        chk("rst_gnt", 64'(c_gnt), 64'h0);
        chk("rst_lock", 64'(m_coh_lock), 64'h0);
        chk("rst_resp", 64'(c_resp), 64'h0);

        // Single client
        step();
        rst = 1'b0;
        c_lock = 2'b01; c_rqst[7:0] = 8'd1; c_trsc[7:0] = 8'd3; c_addr[63:0] = 64'h8000_0040;
        #2;
        chk("idle_no_gnt", 64'(c_gnt), 64'h0);
        chk("idle_no_lock", 64'(m_coh_lock), 64'h0);
        step(); #2;
        chk("single_gnt", 64'(c_gnt), 64'h1);
        chk("single_lock", 64'(m_coh_lock), 64'h1);
        chk("single_rqst", 64'(m_coh_rqst), 64'h1);
        chk("single_trsc", 64'(m_coh_trsc), 64'h3);
        chk("single_addr", m_coh_addr, 64'h8000_0040);
        step();
        m_coh_resp = 8'd1; m_coh_mesi = 8'h04; c_rqst[7:0] = 8'd0;
        #2;
        chk("single_resp", 64'(c_resp), 64'h0001);
        chk("single_mesi", 64'(c_mesi), 64'h0004);
        step();
        m_coh_resp = 8'd0; m_coh_mesi = 8'd0;

        // Reset asserted mid-BUSY
        rst = 1'b1;
        #1;
        chk("midrst_gnt", 64'(c_gnt), 64'h0);
        chk("midrst_lock", 64'(m_coh_lock), 64'h0);
        chk("midrst_addr", m_coh_addr, 64'h0);
        step();
        rst = 1'b0;
        #2;
        chk("postrst_idle", 64'(c_gnt), 64'h0);
        step(); #2;
        chk("postrst_gnt", 64'(c_gnt), 64'h1);

        // Round-robin with GAP=1
        c_lock = 2'b11; c_addr[127:64] = 64'hdead_0000;
        step(); #2;
        chk("rr_hold", 64'(c_gnt), 64'h1);
        c_lock = 2'b10;
        #1;
        chk("rr_rel_lock", 64'(m_coh_lock), 64'h0);
        step(); #2;
        chk("rr_gap_gnt", 64'(c_gnt), 64'h0);
        chk("rr_gap_lock", 64'(m_coh_lock), 64'h0);
        step(); #2;
        chk("rr_idle_gnt", 64'(c_gnt), 64'h0);
        step(); #2;
        chk("rr_gnt1", 64'(c_gnt), 64'h2);
        chk("rr_lock1", 64'(m_coh_lock), 64'h1);
        chk("rr_addr1", m_coh_addr, 64'hdead_0000);
        c_lock = 2'b01;
        step(); step(); step(); #2;
        chk("rr_gnt0", 64'(c_gnt), 64'h1);

        // Isolation: client 1 waiting with a matching request code
        c_lock = 2'b11; c_rqst[15:8] = 8'd1; m_coh_resp = 8'd1; m_coh_mesi = 8'h03;
        #2;
        chk("iso_resp", 64'(c_resp), 64'h0001);
        chk("iso_mesi", 64'(c_mesi), 64'h0003);
        chk("iso_gnt", 64'(c_gnt), 64'h1);
        step(); #2;
        chk("iso_resp_hi", 64'(c_resp[15:8]), 64'h0);
        chk("iso_gnt_hold", 64'(c_gnt), 64'h1);
        m_coh_resp = 8'd0; m_coh_mesi = 8'd0;

        // Drain: request outstanding when lock drops
        c_rqst[7:0] = 8'd1;
        #1;
        chk("drn_rqst", 64'(m_coh_rqst), 64'h1);
        step();
        c_lock = 2'b10; c_rqst[7:0] = 8'd0;
        step();
        c_rqst[7:0] = 8'd5;
        #2;
        chk("drn_gnt", 64'(c_gnt), 64'h0);
        chk("drn_lock", 64'(m_coh_lock), 64'h0);
        chk("drn_rqst0", 64'(m_coh_rqst), 64'h0);
        step(); step();
        m_coh_resp = 8'd1; m_coh_mesi = 8'h02;
        #2;
        chk("drn_resp", 64'(c_resp), 64'h0001);
        chk("drn_mesi", 64'(c_mesi), 64'h0002);
        step();
        m_coh_resp = 8'd0; m_coh_mesi = 8'd0;
        #2;
        chk("drn_gap_gnt", 64'(c_gnt), 64'h0);
        step(); #2;
        chk("drn_idle_gnt", 64'(c_gnt), 64'h0);
        step(); #2;
        chk("drn_next_gnt", 64'(c_gnt), 64'h2);

        // GAP=0 instance: release then immediate re-request by the other client
        rst = 1'b1; c_lock = 2'b00; c_rqst = '0;
        step();
        rst = 1'b0; c_lock = 2'b01;
        step(); #2;
        chk("g0_gnt0", 64'(g0_c_gnt), 64'h1);
        c_lock = 2'b10;
        step(); #2;
        chk("g0_idle", 64'(g0_c_gnt), 64'h0);
        chk("g0_idle_lock", 64'(g0_m_coh_lock), 64'h0);
        step(); #2;
        chk("g0_gnt1", 64'(g0_c_gnt), 64'h2);
        chk("g0_lock1", 64'(g0_m_coh_lock), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dma_coh_arb.md
Name: dma_coh_arb

Overview:
Arbiter that shares the single coherence master interface between N DMA clients, such as the SD card controller wrapper and later peripherals. Each client drives a lock, request, transaction and address bundle, as a DMA wrapper does toward the coherence fabric. The arbiter grants one client at a time in round-robin order and forwards that client's bundle. It routes responses back to the granted client only. It sits between the DMA wrappers and the coherence fabric port.

Parameters:
N, 2, number of DMA clients (2..8)
GAP, 1, idle cycles with m_coh_lock low between consecutive grants (0..15)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
c_lock  in  N  per-client lock request (client i = bit i)
c_rqst  in  8*N  per-client coherence request code; client i at [8i+7:8i]
c_trsc  in  8*N  per-client transaction type
c_addr  in  64*N  per-client block address
c_resp  out  8*N  per-client response; zero for non-granted clients
c_mesi  out  8*N  per-client MESI state; zero for non-granted clients
c_gnt  out  N  one-hot grant, registered
m_coh_lock  out  1  lock to fabric
m_coh_rqst  out  8  forwarded request
m_coh_trsc  out  8  forwarded transaction type
m_coh_addr  out  64  forwarded address
m_coh_resp  in  8  fabric response
m_coh_mesi  in  8  fabric MESI state

Behaviour:
- States: IDLE, BUSY, DRAIN, GAP. gnt is a registered index (clog2(N) bits). ptr is the round-robin pointer.
- Reset, asynchronous: state=IDLE, c_gnt=0, gnt=0, ptr=0, outstanding=0, gap counter=0. All outputs are 0 while rst is high and in IDLE.
- IDLE: if |c_lock, pick the first client with c_lock set, searching from ptr upward and wrapping modulo N. Next cycle: state=BUSY, gnt=index, c_gnt=1<<index. Grant latency is 1 cycle from c_lock rising.
- BUSY, combinational forwarding:
  - m_coh_lock = c_lock[gnt].
  - m_coh_rqst / m_coh_trsc / m_coh_addr = slices of client gnt.
  - c_resp[gnt] = m_coh_resp, c_mesi[gnt] = m_coh_mesi. All other slices are 0.
- Outside BUSY and DRAIN: m_coh_lock=0, m_coh_rqst=0, m_coh_trsc=0, m_coh_addr=0, and all c_resp/c_mesi are 0.
- outstanding flag: set on a cycle with m_coh_rqst!=0 and m_coh_resp==0. Cleared on m_coh_resp!=0. If rqst!=0 and resp!=0 occur in the same cycle, the flag ends clear.
- BUSY -> DRAIN when c_lock[gnt] falls and outstanding=1.
- BUSY -> GAP (or IDLE if GAP=0) when c_lock[gnt] falls and outstanding=0.
- DRAIN:
  - Keep forwarding m_coh_resp/m_coh_mesi to client gnt.
  - m_coh_lock=0 and m_coh_rqst=0.
  - On m_coh_resp!=0, go to GAP (or IDLE if GAP=0).
- On leaving BUSY or DRAIN: c_gnt=0 and ptr=(gnt+1) mod N.
- GAP: count GAP cycles, then go to IDLE. Requests arriving during GAP wait; the grant is issued from IDLE next.
- A client that drops c_lock in the same cycle it is granted receives c_gnt for one cycle, then release follows the normal rules.
- Non-granted clients never see nonzero c_resp/c_mesi, even when m_coh_resp matches their request code.
- A granted client holds the grant indefinitely while c_lock stays high; no preemption.
- Width rules: all slice selection is by gnt; gnt < N always. Bits of c_lock at or above N do not exist.

Test Plan:
- Reset: assert rst mid-BUSY with c_lock=2'b01 -> all outputs 0 immediately; after release, c_gnt=2'b01 one cycle later.
- Single client: c_lock[0]=1, c_rqst[7:0]=1, c_addr=64'h8000_0040 -> next cycle m_coh_lock=1, m_coh_rqst=1, m_coh_addr=64'h8000_0040. m_coh_resp=1 -> c_resp[7:0]=1 and c_resp[15:8]=0.
- Round-robin: both c_lock held, client 0 releases -> GAP for 1 cycle with m_coh_lock=0, then c_gnt=2'b10. Client 1 releases while client 0 requests -> c_gnt=2'b01.
- Drain: client 0 sends rqst=1 then drops c_lock before response -> state DRAIN, m_coh_lock=0; m_coh_resp=1 after 3 cycles goes to c_resp[7:0]; next grant only after GAP.
- Isolation: client 1 waiting while client 0 is granted and m_coh_resp=1 -> c_resp[15:8] stays 0 and c_gnt[1]=0 throughout.
- GAP=0 build: release then immediate re-request by the other client -> grant 2 cycles after release (DRAIN/BUSY exit, then IDLE selection).
